display_scan_ctrl: RTL

//  Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/display_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display showing two 0..63 values.
// Buffer swaps happen only at frame starts, so a frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZB       = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [5:0] i_val_a,
  input  logic [5:0] i_val_b,
  output logic [6:0] o_seg,
  output logic [3:0] o_dig_en,
  output logic       o_frame_done
);

  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_t;

  state_t           r_state;
  logic [1:0]       r_slot;
  logic [CntW-1:0]  r_cnt;
  logic [5:0]       r_act_a, r_act_b;
  logic [5:0]       r_pend_a, r_pend_b;
  logic             r_pend_vld;

  // Values the active buffer takes at a frame start; a coincident load bypasses pending.
  logic [5:0] w_sw_a, w_sw_b;
  assign w_sw_a = i_load ? i_val_a : (r_pend_vld ? r_pend_a : r_act_a);
  assign w_sw_b = i_load ? i_val_b : (r_pend_vld ? r_pend_b : r_act_b);

  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'h01;
      4'd1:    p = 7'h4F;
      4'd2:    p = 7'h12;
      4'd3:    p = 7'h06;
      4'd4:    p = 7'h4C;
      4'd5:    p = 7'h24;
      4'd6:    p = 7'h20;
      4'd7:    p = 7'h0F;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h04;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Odd slots are tens digits; slots 2/3 belong to value B.
  function automatic logic [6:0] seg_for(input logic [1:0] slot, input logic [5:0] a,
                                         input logic [5:0] b);
    logic [5:0] v;
    logic [3:0] tens, units;
    logic [6:0] p;
    v     = slot[1] ? b : a;
    tens  = 4'(v / 6'd10);
    units = 4'(v % 6'd10);
    if (slot[0]) p = (LZB && (tens == 4'd0)) ? 7'h7F : digit_pat(tens);
    else         p = digit_pat(units);
    return p;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_slot       <= 2'd0;
      r_cnt        <= '0;
      r_act_a      <= 6'd0;
      r_act_b      <= 6'd0;
      r_pend_a     <= 6'd0;
      r_pend_b     <= 6'd0;
      r_pend_vld   <= 1'b0;
      o_seg        <= 7'h7F;
      o_dig_en     <= 4'hF;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_load) begin
        r_pend_a   <= i_val_a;
        r_pend_b   <= i_val_b;
        r_pend_vld <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          o_seg    <= 7'h7F;
          o_dig_en <= 4'hF;
          r_slot   <= 2'd0;
          r_cnt    <= '0;
          if (i_en) begin
            r_state    <= StBlank;
            r_act_a    <= w_sw_a;
            r_act_b    <= w_sw_b;
            r_pend_vld <= 1'b0;
            o_seg      <= seg_for(2'd0, w_sw_a, w_sw_b);
          end
        end
        StBlank: begin
          if (!i_en) begin
            r_state  <= StIdle;
            r_slot   <= 2'd0;
            r_cnt    <= '0;
            o_seg    <= 7'h7F;
            o_dig_en <= 4'hF;
          end else if (r_cnt == CntW'(BLANK_CYC - 1)) begin
            r_state  <= StShow;
            r_cnt    <= '0;
            o_dig_en <= ~(4'b0001 << r_slot);
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StShow: begin
          if (!i_en) begin
            r_state  <= StIdle;
            r_slot   <= 2'd0;
            r_cnt    <= '0;
            o_seg    <= 7'h7F;
            o_dig_en <= 4'hF;
          end else if (r_cnt == CntW'(CLK_DIV - 1)) begin
            r_state  <= StBlank;
            r_cnt    <= '0;
            r_slot   <= r_slot + 2'd1;
            o_dig_en <= 4'hF;
            if (r_slot == 2'd3) begin
              o_frame_done <= 1'b1;
              r_act_a      <= w_sw_a;
              r_act_b      <= w_sw_b;
              r_pend_vld   <= 1'b0;
              o_seg        <= seg_for(2'd0, w_sw_a, w_sw_b);
            end else begin
              o_seg <= seg_for(r_slot + 2'd1, r_act_a, r_act_b);
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state  <= StIdle;
          r_slot   <= 2'd0;
          r_cnt    <= '0;
          o_seg    <= 7'h7F;
          o_dig_en <= 4'hF;
        end
      endcase
    end
  end

endmodule
